aes_gcm_ctr_gen: RTL and testbench
==================================

AES_GCM_CTR_GEN -- requirements
Module: aes_gcm_ctr_gen

Interface
REQ-001 Parameter LANES, default 4, number of counter blocks emitted per beat; legal values 1, 2, 4.
REQ-002 Parameter CTR_W, default 32, width of the incrementing counter field (low CTR_W bits of the 128-bit block); legal range 8..64.
REQ-003 Parameter ROUND, default 1, AES round index applied by fn_aes_encrypt_stage when the round feature is compiled in.
REQ-004 There SHALL be one clock; reset is synchronous and active-high.
REQ-005 Port list (name  direction  width  meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_valid  in  1  instance request valid.
- o_ready  out  1  block accepts an instance.
- i_j0  in  128 [0:127]  pre-counter block J0.
- i_num_blocks  in  32  counter blocks in the instance.
- i_key_schedule  in  1408 [0:1407]  expanded key.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts beat.
- o_cb  out  128*LANES  lane k at bits [128k:128k+127].
- o_cb_round  out  128*LANES  ROUND-stage transform of each o_cb lane.
- o_j0_round  out  128  ROUND-stage transform of J0; meaningful when o_first=1.
- o_lane_mask  out  LANES  bit k set = lane k carries a real block.
- o_first  out  1  first beat of instance.
- o_last  out  1  final beat of instance.

Function
REQ-006 FSM states IDLE, RUN; o_ready=1 only in IDLE.
REQ-007 Handshake i_valid&&o_ready in IDLE SHALL register J0, num_blocks and key schedule, set remaining=num_blocks and index=1, and enter RUN.
REQ-008 First beat SHALL present o_valid=1 on the cycle after acceptance, with o_first=1.
REQ-009 Lane k of a beat SHALL carry {J0[0:127-CTR_W], (J0 low CTR_W bits + index + k) mod 2^CTR_W}; upper 128-CTR_W bits never change.
REQ-010 o_lane_mask SHALL have min(remaining, LANES) low bits set; unset lanes output all-zero o_cb and o_cb_round.
REQ-011 o_last=1 when remaining <= LANES.
REQ-012 On o_valid&&i_ready: if o_last, return to IDLE with o_valid=0 next cycle; else index+=LANES, remaining-=LANES, next beat presented next cycle (one beat per cycle sustained).
REQ-013 While o_valid=1 and i_ready=0, all outputs SHALL hold stable.
REQ-014 num_blocks=0 SHALL produce one beat: o_lane_mask=0, o_first=o_last=1, o_j0_round valid.
REQ-015 Counter wrap SHALL be modulo 2^CTR_W without carry into upper bits or error.
REQ-016 i_valid in RUN is ignored; no request is queued.

Reset
REQ-017 With rst=1 at a clock edge: state=IDLE, o_valid=0, o_first=0, o_last=0, o_lane_mask=0, o_cb=0, o_cb_round=0, o_j0_round=0, internal counters=0; o_ready=1 from the cycle after reset deasserts.
REQ-018 Reset in RUN SHALL abort the instance with no further beats.

Configuration
REQ-019 Macro AES_GCM_CTR_ROUND_EN defined: o_cb_round and o_j0_round = fn_aes_encrypt_stage(block, key schedule, ROUND), registered with the beat.
REQ-020 Macro AES_GCM_CTR_ROUND_EN undefined: o_cb_round and o_j0_round tied to 0, key schedule not registered; all other behaviour identical.

Verification
REQ-021 LANES=4, CTR_W=32, J0 low word 0x00000001, num_blocks=5, i_ready=1 -> beat1 counters 2,3,4,5, mask 1111, first; beat2 counter 6, mask 0001, last; o_ready=1 two cycles after beat2.
REQ-022 J0 low word 0xFFFFFFFE, num_blocks=3 -> counters 0xFFFFFFFF, 0x00000000, 0x00000001, mask 0111, upper 96 bits equal J0.
REQ-023 num_blocks=9, i_ready low 3 cycles on beat2 -> beat2 outputs stable all 3 cycles; third beat carries index 9 with mask 0001, last.
REQ-024 num_blocks=0 -> single beat, mask 0000, o_first=o_last=1; with macro, o_j0_round matches reference model.
REQ-025 rst pulsed after first beat of num_blocks=12 -> o_valid=0 next cycle, o_ready=1 after release, new instance starts at index 1.

Source files
------------

// File: rtl/aes_gcm_ctr_gen.sv
// aes_gcm_ctr_gen: GCM counter-block generator. After accepting J0, a block count
// and an expanded key, it emits LANES counter blocks per beat under a valid/ready
// handshake. Only the low CTR_W bits of each block increment, modulo 2^CTR_W.
// Optional feature macro AES_GCM_CTR_ROUND_EN: when defined, each emitted block and
// J0 also pass through one AES round stage (index ROUND) and the result is
// registered with the beat. When undefined, those outputs are tied to zero.
module aes_gcm_ctr_gen #(
    parameter int LANES = 4,
    parameter int CTR_W = 32,
    parameter int ROUND = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [0:127]         i_j0,
    input  logic [31:0]          i_num_blocks,
    input  logic [0:1407]        i_key_schedule,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [0:128*LANES-1] o_cb,
    output logic [0:128*LANES-1] o_cb_round,
    output logic [0:127]         o_j0_round,
    output logic [LANES-1:0]     o_lane_mask,
    output logic                 o_first,
    output logic                 o_last
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                 r_state;
    logic                   r_ready;
    logic                   r_valid;
    logic                   r_first;
    logic                   r_last;
    logic [LANES-1:0]       r_mask;
    logic [0:128*LANES-1]   r_cb;
    logic [0:127]           r_j0;
    logic [CTR_W-1:0]       r_idx;
    logic [31:0]            r_rem;

    logic                   w_accept;
    logic                   w_advance;
    logic                   w_done;
    logic [0:127]           w_src_j0;
    logic [CTR_W-1:0]       w_src_idx;
    logic [31:0]            w_src_rem;
    logic [CTR_W-1:0]       w_ctr_base;
    logic [0:127]           w_lane_blk [LANES];
    logic [0:128*LANES-1]   w_cb;
    logic [LANES-1:0]       w_mask;
    logic                   w_last;

`ifdef AES_GCM_CTR_ROUND_EN
    logic [0:1407]          r_key;
    logic [0:128*LANES-1]   r_cb_round;
    logic [0:127]           r_j0_round;
    logic [0:1407]          w_key_src;
    logic [0:128*LANES-1]   w_cb_round;
    logic [0:127]           w_j0_round;

    function automatic logic [7:0] fn_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] fn_gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = fn_xtime(aa);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (x^254) followed by the AES affine map.
    function automatic logic [7:0] fn_sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] inv;
        p   = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = fn_gf_mul(p, p);
            inv = fn_gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // One AES encryption round with round key rnd: round 0 is key addition only,
    // round 10 omits MixColumns, other rounds are full rounds.
    function automatic logic [0:127] fn_aes_encrypt_stage(input logic [0:127] blk,
                                                          input logic [0:1407] ks,
                                                          input int rnd);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [0:127] o;
        logic [0:127] rk;
        rk = ks[128*rnd +: 128];
        for (int i = 0; i < 16; i++) begin
            s[i] = blk[8*i +: 8];
        end
        if (rnd == 0) begin
            o = blk;
        end else begin
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    t[r + 4*c] = fn_sbox(s[r + 4*((c + r) % 4)]);
                end
            end
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rnd == 10) begin
                    o[32*c +: 32] = {a0, a1, a2, a3};
                end else begin
                    o[32*c +: 32] = {fn_xtime(a0) ^ fn_xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ fn_xtime(a1) ^ fn_xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ fn_xtime(a2) ^ fn_xtime(a3) ^ a3,
                                     fn_xtime(a0) ^ a0 ^ a1 ^ a2 ^ fn_xtime(a3)};
                end
            end
        end
        return o ^ rk;
    endfunction
`else
    logic w_unused_ok;
    assign w_unused_ok = (^i_key_schedule) ^ (ROUND != 0);
`endif

    assign w_accept  = r_ready && i_valid;
    assign w_advance = r_valid && i_ready && !r_last;
    assign w_done    = r_valid && i_ready && r_last;

    // Choose the source of the next beat: a fresh instance or the next step of the current one.
    always_comb begin
        if (w_accept) begin
            w_src_j0  = i_j0;
            w_src_idx = CTR_W'(32'd1);
            w_src_rem = i_num_blocks;
        end else begin
            w_src_j0  = r_j0;
            w_src_idx = r_idx + CTR_W'(LANES);
            w_src_rem = r_rem - 32'(LANES);
        end
    end

    // Build the counter blocks, lane mask and last flag for the next beat.
    always_comb begin
        w_ctr_base = w_src_j0[128-CTR_W:127];
        w_cb       = {(128*LANES){1'b0}};
        w_mask     = {LANES{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            w_lane_blk[k] = {w_src_j0[0:127-CTR_W], w_ctr_base + w_src_idx + CTR_W'(k)};
            if (w_src_rem > 32'(k)) begin
                w_cb[128*k +: 128] = w_lane_blk[k];
                w_mask[k]          = 1'b1;
            end else begin
                w_cb[128*k +: 128] = 128'd0;
                w_mask[k]          = 1'b0;
            end
        end
        w_last = (w_src_rem <= 32'(LANES));
    end

`ifdef AES_GCM_CTR_ROUND_EN
    // Round-stage transform of every live lane and of J0, using the instance key.
    always_comb begin
        if (w_accept) begin
            w_key_src = i_key_schedule;
        end else begin
            w_key_src = r_key;
        end
        w_cb_round = {(128*LANES){1'b0}};
        for (int k = 0; k < LANES; k++) begin
            if (w_mask[k]) begin
                w_cb_round[128*k +: 128] = fn_aes_encrypt_stage(w_lane_blk[k], w_key_src, ROUND);
            end else begin
                w_cb_round[128*k +: 128] = 128'd0;
            end
        end
        w_j0_round = fn_aes_encrypt_stage(w_src_j0, w_key_src, ROUND);
    end

    // Round-stage results are captured together with the beat they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key      <= 1408'd0;
            r_cb_round <= {(128*LANES){1'b0}};
            r_j0_round <= 128'd0;
        end else if (w_accept || w_advance) begin
            r_key      <= w_key_src;
            r_cb_round <= w_cb_round;
            r_j0_round <= w_j0_round;
        end else if (w_done) begin
            r_cb_round <= {(128*LANES){1'b0}};
            r_j0_round <= 128'd0;
        end else begin
            r_key      <= r_key;
        end
    end

    assign o_cb_round = r_cb_round;
    assign o_j0_round = r_j0_round;
`else
    assign o_cb_round = {(128*LANES){1'b0}};
    assign o_j0_round = 128'd0;
`endif

    // Control FSM: accept in IDLE, emit one beat per accepted handshake in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_mask  <= {LANES{1'b0}};
            r_cb    <= {(128*LANES){1'b0}};
            r_j0    <= 128'd0;
            r_idx   <= {CTR_W{1'b0}};
            r_rem   <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b0;
                        r_valid <= 1'b1;
                        r_first <= 1'b1;
                        r_last  <= w_last;
                        r_mask  <= w_mask;
                        r_cb    <= w_cb;
                        r_j0    <= w_src_j0;
                        r_idx   <= w_src_idx;
                        r_rem   <= w_src_rem;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_ready <= 1'b0;
                    if (w_done) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_first <= 1'b0;
                        r_last  <= 1'b0;
                        r_mask  <= {LANES{1'b0}};
                        r_cb    <= {(128*LANES){1'b0}};
                    end else if (w_advance) begin
                        r_first <= 1'b0;
                        r_last  <= w_last;
                        r_mask  <= w_mask;
                        r_cb    <= w_cb;
                        r_idx   <= w_src_idx;
                        r_rem   <= w_src_rem;
                    end else begin
                        r_valid <= r_valid;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready     = r_ready;
    assign o_valid     = r_valid;
    assign o_first     = r_first;
    assign o_last      = r_last;
    assign o_lane_mask = r_mask;
    assign o_cb        = r_cb;

endmodule

// File: tb/tb_aes_gcm_ctr_gen.sv
// Directed bench for aes_gcm_ctr_gen with default parameters (LANES=4, CTR_W=32, ROUND=1).
module tb_aes_gcm_ctr_gen;

    logic           clk;
    logic           rst;
    logic           i_valid;
    logic           o_ready;
    logic [0:127]   i_j0;
    logic [31:0]    i_num_blocks;
    logic [0:1407]  i_key_schedule;
    logic           o_valid;
    logic           i_ready;
    logic [0:511]   o_cb;
    logic [0:511]   o_cb_round;
    logic [0:127]   o_j0_round;
    logic [3:0]     o_lane_mask;
    logic           o_first;
    logic           o_last;

    int checks = 0;
    int errors = 0;

    logic [0:95]  u_a = 96'h0123456789abcdeffedcba98;
    logic [0:95]  u_b = 96'hcafef00d1122334455667788;
    logic [0:511] exp_cb;
    logic [0:127] exp_j0r;

    aes_gcm_ctr_gen #(.LANES(4), .CTR_W(32), .ROUND(1)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_j0(i_j0), .i_num_blocks(i_num_blocks), .i_key_schedule(i_key_schedule),
        .o_valid(o_valid), .i_ready(i_ready), .o_cb(o_cb), .o_cb_round(o_cb_round),
        .o_j0_round(o_j0_round), .o_lane_mask(o_lane_mask), .o_first(o_first), .o_last(o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_inst(input logic [0:127] j0, input logic [31:0] n);
        int waited = 0;
        while (!o_ready && waited < 20) begin
            step();
            waited++;
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_ready got %b want 1 (timeout)", o_ready);
        end
        i_j0 = j0;
        i_num_blocks = n;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int waited = 0;
        while (!o_ready && waited < 20) begin
            step();
            waited++;
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_idle got o_ready=%b want 1 (timeout)", o_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({o_valid, o_ready, o_first, o_last, o_lane_mask} !== 8'b0) begin
            errors++;
            $display("FAIL reset_ctrl got v=%b r=%b f=%b l=%b m=%b want all 0",
                     o_valid, o_ready, o_first, o_last, o_lane_mask);
        end
        checks++;
        if ({o_cb, o_cb_round, o_j0_round} !== 1152'd0) begin
            errors++;
            $display("FAIL reset_data got cb=%h j0r=%h want 0", o_cb, o_j0_round);
        end
        rst = 1'b0;
        step();
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b want 1", o_ready);
        end
    endtask

    task automatic test_basic();
        start_inst({u_a, 32'h00000001}, 32'd5);
        exp_cb = {u_a, 32'h2, u_a, 32'h3, u_a, 32'h4, u_a, 32'h5};
        checks++;
        if (o_cb !== exp_cb) begin
            errors++;
            $display("FAIL basic_beat1_cb got %h want %h", o_cb, exp_cb);
        end
        checks++;
        if ({o_valid, o_first, o_last, o_lane_mask} !== 7'b1101111) begin
            errors++;
            $display("FAIL basic_beat1_ctrl got v=%b f=%b l=%b m=%b want 1 1 0 1111",
                     o_valid, o_first, o_last, o_lane_mask);
        end
`ifndef AES_GCM_CTR_ROUND_EN
        checks++;
        if (o_cb_round !== 512'd0) begin
            errors++;
            $display("FAIL basic_round_tied got %h want 0", o_cb_round);
        end
`endif
        // A request while running must be ignored.
        i_j0 = {u_b, 32'h00000100};
        i_num_blocks = 32'd2;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        exp_cb = {u_a, 32'h6, 384'd0};
        checks++;
        if (o_cb !== exp_cb) begin
            errors++;
            $display("FAIL basic_beat2_cb got %h want %h", o_cb, exp_cb);
        end
        checks++;
        if ({o_valid, o_first, o_last, o_lane_mask} !== 7'b1010001) begin
            errors++;
            $display("FAIL basic_beat2_ctrl got v=%b f=%b l=%b m=%b want 1 0 1 0001",
                     o_valid, o_first, o_last, o_lane_mask);
        end
        step();
        checks++;
        if ({o_valid, o_ready} !== 2'b00) begin
            errors++;
            $display("FAIL basic_after_last got v=%b r=%b want 0 0", o_valid, o_ready);
        end
        step();
        checks++;
        if ({o_valid, o_ready} !== 2'b01) begin
            errors++;
            $display("FAIL basic_ready_back got v=%b r=%b want 0 1", o_valid, o_ready);
        end
    endtask

    task automatic test_wrap();
        start_inst({u_b, 32'hfffffffe}, 32'd3);
        exp_cb = {u_b, 32'hffffffff, u_b, 32'h00000000, u_b, 32'h00000001, 128'd0};
        checks++;
        if (o_cb !== exp_cb) begin
            errors++;
            $display("FAIL wrap_cb got %h want %h", o_cb, exp_cb);
        end
        checks++;
        if ({o_valid, o_first, o_last, o_lane_mask} !== 7'b1110111) begin
            errors++;
            $display("FAIL wrap_ctrl got v=%b f=%b l=%b m=%b want 1 1 1 0111",
                     o_valid, o_first, o_last, o_lane_mask);
        end
        wait_idle();
    endtask

    task automatic test_back_pressure();
        start_inst({u_a, 32'h00000010}, 32'd9);
        exp_cb = {u_a, 32'h11, u_a, 32'h12, u_a, 32'h13, u_a, 32'h14};
        checks++;
        if (o_cb !== exp_cb) begin
            errors++;
            $display("FAIL bp_beat1_cb got %h want %h", o_cb, exp_cb);
        end
        step();
        i_ready = 1'b0;
        exp_cb = {u_a, 32'h15, u_a, 32'h16, u_a, 32'h17, u_a, 32'h18};
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (o_cb !== exp_cb || {o_valid, o_first, o_last, o_lane_mask} !== 7'b1001111) begin
                errors++;
                $display("FAIL bp_hold_%0d got cb=%h v=%b f=%b l=%b m=%b want cb=%h 1 0 0 1111",
                         c, o_cb, o_valid, o_first, o_last, o_lane_mask, exp_cb);
            end
            if (c < 3) step();
        end
        i_ready = 1'b1;
        step();
        exp_cb = {u_a, 32'h19, 384'd0};
        checks++;
        if (o_cb !== exp_cb || {o_valid, o_first, o_last, o_lane_mask} !== 7'b1010001) begin
            errors++;
            $display("FAIL bp_beat3 got cb=%h v=%b f=%b l=%b m=%b want cb=%h 1 0 1 0001",
                     o_cb, o_valid, o_first, o_last, o_lane_mask, exp_cb);
        end
        wait_idle();
    endtask

    task automatic test_zero_blocks();
        i_key_schedule = 1408'd0;
        i_key_schedule[128:255] = 128'ha0fafe1788542cb123a339392a6c7605;
`ifdef AES_GCM_CTR_ROUND_EN
        exp_j0r = 128'ha49c7ff2689f352b6b5bea43026a5049;
`else
        exp_j0r = 128'd0;
`endif
        start_inst(128'h193de3bea0f4e22b9ac68d2ae9f84808, 32'd0);
        checks++;
        if ({o_valid, o_first, o_last, o_lane_mask} !== 7'b1110000) begin
            errors++;
            $display("FAIL zero_ctrl got v=%b f=%b l=%b m=%b want 1 1 1 0000",
                     o_valid, o_first, o_last, o_lane_mask);
        end
        checks++;
        if ({o_cb, o_cb_round} !== 1024'd0) begin
            errors++;
            $display("FAIL zero_lanes got cb=%h cbr=%h want 0", o_cb, o_cb_round);
        end
        checks++;
        if (o_j0_round !== exp_j0r) begin
            errors++;
            $display("FAIL zero_j0_round got %h want %h", o_j0_round, exp_j0r);
        end
        wait_idle();
    endtask

    task automatic test_reset_abort();
        start_inst({u_b, 32'h00000100}, 32'd12);
        exp_cb = {u_b, 32'h101, u_b, 32'h102, u_b, 32'h103, u_b, 32'h104};
        checks++;
        if (o_cb !== exp_cb || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_beat1 got cb=%h v=%b want cb=%h v=1", o_cb, o_valid, exp_cb);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({o_valid, o_ready, o_lane_mask} !== 6'b0 || o_cb !== 512'd0) begin
            errors++;
            $display("FAIL abort_reset got v=%b r=%b m=%b cb=%h want 0", o_valid, o_ready,
                     o_lane_mask, o_cb);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({o_valid, o_ready} !== 2'b01) begin
            errors++;
            $display("FAIL abort_ready got v=%b r=%b want 0 1", o_valid, o_ready);
        end
        start_inst({u_a, 32'h00000200}, 32'd2);
        exp_cb = {u_a, 32'h201, u_a, 32'h202, 256'd0};
        checks++;
        if (o_cb !== exp_cb || {o_valid, o_first, o_last, o_lane_mask} !== 7'b1110011) begin
            errors++;
            $display("FAIL abort_restart got cb=%h v=%b f=%b l=%b m=%b want cb=%h 1 1 1 0011",
                     o_cb, o_valid, o_first, o_last, o_lane_mask, exp_cb);
        end
        wait_idle();
    endtask

    initial begin
        rst = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_j0 = 128'd0;
        i_num_blocks = 32'd0;
        i_key_schedule = 1408'd0;
        test_reset();
        test_basic();
        test_wrap();
        test_back_pressure();
        test_zero_blocks();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
